// File: rtl/xs3_pkg.sv
// Shared types and constants for the BCD to Excess-3 sequencer.
package xs3_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  localparam int         DIGIT_W    = 4;
  localparam logic [3:0] XS3_OFFSET = 4'd3;
  localparam logic [3:0] BCD_MAX    = 4'd9;

endpackage

// File: rtl/xs3_digit_conv.sv
// Single-digit Excess-3 converter: y = (d + 3) mod 16, no range check.
module xs3_digit_conv
  import xs3_pkg::*;
(
  input  logic [DIGIT_W-1:0] d,
  output logic [DIGIT_W-1:0] y
);

  assign y = d + XS3_OFFSET;

endmodule

// File: rtl/bcd_xs3_seq.sv
// Converts a packed BCD word to Excess-3 one digit per clock through one shared converter.
// Optional range check enabled by defining BCD_XS3_ERRCHK_EN.
//
// state | meaning
// IDLE  | waiting for a word, in_ready high
// CONV  | converting digit idx, LSB first
// DONE  | result held on out_xs3 until out_ready
module bcd_xs3_seq
  import xs3_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIGIT_W*DIGITS-1:0] in_bcd,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIGIT_W*DIGITS-1:0] out_xs3,
  output logic                      out_err,
  output logic                      busy
);

  localparam int W     = DIGIT_W * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  state_t             state_q, state_d;
  logic [W-1:0]       src_q, src_d;
  logic [W-1:0]       res_q, res_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               err_q, err_d;
  logic [DIGIT_W-1:0] digit;
  logic [DIGIT_W-1:0] conv_y;
  logic [DIGIT_W-1:0] nib;

  xs3_digit_conv u_conv (
    .d (digit),
    .y (conv_y)
  );

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    res_d   = res_q;
    idx_d   = idx_q;
    err_d   = err_q;
    digit   = '0;

    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) digit = src_q[i*DIGIT_W +: DIGIT_W];
    end

    nib = conv_y;
`ifdef BCD_XS3_ERRCHK_EN
    // Out-of-range digits produce a zero nibble rather than a wrapped code.
    if (digit > BCD_MAX) nib = '0;
`endif

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          src_d   = in_bcd;
          res_d   = '0;
          idx_d   = '0;
          err_d   = 1'b0;
          state_d = CONV;
        end
      end
      CONV: begin
        for (int i = 0; i < DIGITS; i++) begin
          if (idx_q == IDX_W'(i)) res_d[i*DIGIT_W +: DIGIT_W] = nib;
        end
`ifdef BCD_XS3_ERRCHK_EN
        if (digit > BCD_MAX) err_d = 1'b1;
`endif
        if (idx_q == LAST_IDX) state_d = DONE;
        else                   idx_d   = idx_q + 1'b1;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  // Without the range check err_q is never set, so out_err stays 0.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_xs3   = res_q;
  assign out_err   = err_q;

endmodule

// File: doc/bcd_xs3_seq.md
# bcd_xs3_seq

Sequencing controller that converts a multi-digit packed BCD word to packed Excess-3, one digit per clock, through a single shared 4-bit digit converter. It sits between a BCD producer and an Excess-3 consumer, with a valid/ready handshake on each side. It holds one word at a time and does not pipeline words. It trades throughput for a single converter instance.

## Interface
Parameters:
- DIGITS, 4: number of BCD digits per word (≥1); word width W = 4*DIGITS.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  producer has a word on in_bcd.
- in_ready  out  1  block accepts a word this cycle.
- in_bcd  in  W  packed BCD; digit i = in_bcd[4i+3:4i].
- out_valid  out  1  out_xs3 holds a completed word.
- out_ready  in  1  consumer takes the word this cycle.
- out_xs3  out  W  packed Excess-3 result, same digit order.
- out_err  out  1  at least one input digit was >9 (see Configuration).
- busy  out  1  high in CONV or DONE.

## Operation
- FSM states: IDLE, CONV, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, capture in_bcd into the source register and clear the result register, digit index and error flag.
  - Go to CONV.
- CONV:
  - Each cycle, route digit[idx] through the converter and write the result into nibble idx of the result register. Then increment idx.
  - Order is LSB digit first.
  - When idx reaches DIGITS-1 and that digit has been written, go to DONE.
- DONE:
  - out_valid=1. out_xs3 and out_err are held stable.
  - On out_valid&out_ready, go to IDLE.
- Converter arithmetic: y = (d + 3) mod 16 on 4 bits; no carry between digits.
- in_ready is high only in IDLE. in_valid is ignored in CONV and DONE.
- out_xs3 keeps its last value after the handshake until the next word starts. The bench checks out_xs3 only while out_valid=1.
- Reset values: state IDLE, in_ready=1 (combinational from IDLE), out_valid=0, out_xs3=0, out_err=0, busy=0, idx=0.
- Reset mid-CONV or mid-DONE: the word is discarded with no output and the block returns to IDLE.

## Timing
- Acceptance edge E0.
- Digit i is written at edge E0+1+i.
- out_valid rises after edge E0+DIGITS, so latency is DIGITS cycles.
- Earliest output handshake is edge E0+DIGITS+1. in_ready is high again in the following cycle.
- Best-case throughput: one word per DIGITS+2 cycles.
- out_ready low in DONE: hold indefinitely, with no output change.
- out_ready may be high before DONE. It has no effect until out_valid=1.
- DIGITS=1: CONV lasts exactly one cycle.

## Configuration
- Macro BCD_XS3_ERRCHK_EN. When defined:
  - Each digit >9 sets the sticky error flag.
  - That digit's result nibble is forced to 4'b0000.
  - out_err is valid with out_valid.
- When not defined:
  - No range check is made, and out_err is tied to 0.
  - Digits >9 convert by the modular rule (e.g. 0xD→0x0).

## Structure
- Package xs3_pkg holds:
  - the state typedef (IDLE, CONV, DONE);
  - DIGIT_W=4, XS3_OFFSET=4'd3, BCD_MAX=4'd9.
- Sub-module xs3_digit_conv: combinational 4-bit d→(d+3) mod 16, instantiated once.
- Range checking lives in the controller, not in the sub-module.

## Test plan
- DIGITS=4, in_bcd=0x1995, out_ready=1 → out_xs3=0x4CC8, out_err=0, out_valid 4 cycles after acceptance.
- in_bcd=0x0000 then 0x9999 back-to-back, with in_valid held high → 0x3333 then 0xCCCC. in_ready is low for exactly 5 cycles between the two acceptances.
- With BCD_XS3_ERRCHK_EN, in_bcd=0x12A4 → out_xs3=0x4507, out_err=1. Without the macro → out_xs3=0x45D7, out_err=0.
- Backpressure: out_ready low for 6 cycles in DONE → out_valid stays 1, out_xs3 stays stable, in_ready stays 0. The handshake completes on the 7th cycle.
- rst pulsed during CONV (after 2 digits) → out_valid=0, out_xs3=0 and in_ready=1 immediately. The next word 0x0428 → 0x375B.
- DIGITS=1, in_bcd=0x7 → out_xs3=0xA, 1-cycle latency.
